// File: rtl/alu_accum_core_if.sv
// Operand/result handshake bundle for alu_accum_core.
// master = producer/consumer side (drives operands, takes results); slave = the core.
interface alu_accum_core_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ACC_W = 16
) ();
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic             acc_clr;
  logic [ACC_W-1:0] result;
  logic             out_valid;
  logic             out_ready;
  logic             acc_ovf;

  modport master (
    output a, b, op, in_valid, acc_clr, out_ready,
    input  in_ready, result, out_valid, acc_ovf
  );

  modport slave (
    input  a, b, op, in_valid, acc_clr, out_ready,
    output in_ready, result, out_valid, acc_ovf
  );
endinterface

// File: rtl/alu_accum_core.sv
// Pipelined 16-opcode ALU with registered valid/ready result and a sticky-overflow accumulator.
// Optional macro ALU_SAT_EN: accumulator saturates at all-ones instead of wrapping.
module alu_accum_core #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ACC_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  alu_accum_core_if.slave  bus
);

  localparam int unsigned CW = 2 * WIDTH;

  typedef enum logic [3:0] {
    OP_AND  = 4'h0, OP_OR   = 4'h1, OP_NOT  = 4'h2, OP_XOR  = 4'h3,
    OP_NAND = 4'h4, OP_NOR  = 4'h5, OP_XNOR = 4'h6, OP_ADD  = 4'h7,
    OP_SUB  = 4'h8, OP_MUL  = 4'h9, OP_CMP  = 4'hA, OP_SLL  = 4'hB,
    OP_SRL  = 4'hC, OP_SLA  = 4'hD, OP_SRA  = 4'hE, OP_ACC  = 4'hF
  } op_e;

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("alu_accum_core: WIDTH must be in 2..16");
  end
  if (ACC_W < CW) begin : g_bad_acc_w
    $error("alu_accum_core: ACC_W must be >= 2*WIDTH");
  end

  logic [ACC_W-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_ovf_q, acc_ovf_d;

  logic             in_ready;
  logic             accept;
  op_e              op;
  logic [CW-1:0]    c;
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [CW-1:0]    mul_w;
  logic [1:0]       cmp_w;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W:0]   acc_sum;
  logic             acc_carry;
  logic [ACC_W-1:0] acc_add;
  logic [ACC_W-1:0] alu_res;

  assign op       = op_e'(bus.op);
  assign c        = {bus.a, bus.b};
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    add_w = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w = {1'b0, bus.a} - {1'b0, bus.b};
    mul_w = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
    if (bus.a > bus.b)      cmp_w = 2'b10;
    else if (bus.a < bus.b) cmp_w = 2'b01;
    else                    cmp_w = 2'b11;
  end

  // Clear takes effect before the add, so a same-cycle clear+ACC yields acc = C.
  always_comb begin
    acc_base  = bus.acc_clr ? '0 : acc_q;
    acc_sum   = {1'b0, acc_base} + {{(ACC_W + 1 - CW){1'b0}}, c};
    acc_carry = acc_sum[ACC_W];
`ifdef ALU_SAT_EN
    acc_add   = acc_carry ? '1 : acc_sum[ACC_W-1:0];
`else
    acc_add   = acc_sum[ACC_W-1:0];
`endif
  end

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_AND:  alu_res[WIDTH-1:0] = bus.a & bus.b;
      OP_OR:   alu_res[WIDTH-1:0] = bus.a | bus.b;
      OP_NOT:  alu_res[CW-1:0]    = {~bus.a, ~bus.b};
      OP_XOR:  alu_res[WIDTH-1:0] = bus.a ^ bus.b;
      OP_NAND: alu_res[WIDTH-1:0] = ~(bus.a & bus.b);
      OP_NOR:  alu_res[WIDTH-1:0] = ~(bus.a | bus.b);
      OP_XNOR: alu_res[WIDTH-1:0] = ~(bus.a ^ bus.b);
      OP_ADD:  alu_res[WIDTH:0]   = add_w;
      OP_SUB:  alu_res[WIDTH:0]   = sub_w;
      OP_MUL:  alu_res[CW-1:0]    = mul_w;
      OP_CMP:  alu_res[1:0]       = cmp_w;
      OP_SLL:  alu_res[CW-1:0]    = {c[CW-2:0], 1'b0};
      OP_SRL:  alu_res[CW-1:0]    = {1'b0, c[CW-1:1]};
      OP_SLA:  alu_res[CW-1:0]    = {c[CW-2:0], 1'b0};
      OP_SRA:  alu_res[CW-1:0]    = {c[CW-1], c[CW-1:1]};
      OP_ACC:  alu_res            = acc_add;
    endcase
  end

  always_comb begin
    result_d    = result_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      result_d    = alu_res;
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // A stalled ACC leaves acc alone, but a concurrent clear still applies.
  always_comb begin
    acc_d     = acc_base;
    acc_ovf_d = bus.acc_clr ? 1'b0 : acc_ovf_q;
    if (accept && op == OP_ACC) begin
      acc_d     = acc_add;
      acc_ovf_d = acc_ovf_d | acc_carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      acc_q       <= '0;
      acc_ovf_q   <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      acc_q       <= acc_d;
      acc_ovf_q   <= acc_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_alu_accum_core.sv
// Directed + randomized bench for alu_accum_core (WIDTH=4, ACC_W=16) against an integer reference model.
module tb_alu_accum_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ov  = 0;
  int m_res = 0;
  int m_acc = 0;
  int m_ovf = 0;
  int held;

  alu_accum_core_if #(.WIDTH(4), .ACC_W(16)) bus ();

  alu_accum_core #(.WIDTH(4), .ACC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int ref_alu(input int op, input int a, input int b);
    int c;
    c = a * 16 + b;
    case (op)
      0:  return a & b;
      1:  return a | b;
      2:  return (15 - a) * 16 + (15 - b);
      3:  return a ^ b;
      4:  return 15 - (a & b);
      5:  return 15 - (a | b);
      6:  return 15 - (a ^ b);
      7:  return a + b;
      8:  return (a - b + 32) % 32;
      9:  return a * b;
      10: return (a > b) ? 2 : ((a < b) ? 1 : 3);
      11: return (c * 2) % 256;
      12: return c / 2;
      13: return (c * 2) % 256;
      14: return c / 2 + ((c >= 128) ? 128 : 0);
      default: return 0;
    endcase
  endfunction

  // Entered and left at posedge+1: drive, check in_ready, clock, update model, check outputs.
  task automatic cycle(input int v, input int op, input int a, input int b, input int clr, input int ordy);
    int acc_ok;
    int s;
    bus.in_valid  = v[0];
    bus.op        = op[3:0];
    bus.a         = a[3:0];
    bus.b         = b[3:0];
    bus.acc_clr   = clr[0];
    bus.out_ready = ordy[0];
    #1;
    acc_ok = (v != 0) && (m_ov == 0 || ordy != 0);
    check("in_ready", {31'b0, bus.in_ready}, (m_ov == 0 || ordy != 0) ? 1 : 0);
    @(posedge clk);
    if (clr != 0) begin
      m_acc = 0;
      m_ovf = 0;
    end
    if (acc_ok) begin
      if (op == 15) begin
        s = m_acc + a * 16 + b;
        if (s > 65535) begin
          m_ovf = 1;
`ifdef ALU_SAT_EN
          s = 65535;
`else
          s = s - 65536;
`endif
        end
        m_acc = s;
        m_res = s;
      end else begin
        m_res = ref_alu(op, a, b);
      end
      m_ov = 1;
    end else if (ordy != 0) begin
      m_ov = 0;
    end
    #1;
    check("out_valid", {31'b0, bus.out_valid}, m_ov);
    check("acc_ovf", {31'b0, bus.acc_ovf}, m_ovf);
    if (m_ov != 0) check("result", {16'b0, bus.result}, m_res);
  endtask

  initial begin
    bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.acc_clr = 0; bus.out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 0);
    check("rst_result", {16'b0, bus.result}, 0);
    check("rst_acc_ovf", {31'b0, bus.acc_ovf}, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Arithmetic, each visible one cycle after accept
    cycle(1, 7, 15, 1, 0, 1); check("add_F_1", {16'b0, bus.result}, 32'h10);
    cycle(1, 8, 2, 5, 0, 1);  check("sub_2_5", {16'b0, bus.result}, 32'h1D);
    cycle(1, 9, 15, 15, 0, 1); check("mul_F_F", {16'b0, bus.result}, 32'hE1);
    cycle(1, 10, 3, 3, 0, 1); check("cmp_eq", {16'b0, bus.result}, 32'h3);
    cycle(1, 2, 5, 0, 0, 1);  check("not_5_0", {16'b0, bus.result}, 32'hAF);
    cycle(1, 14, 8, 1, 0, 1); check("sra_81", {16'b0, bus.result}, 32'hC0);
    cycle(1, 12, 8, 1, 0, 1); check("srl_81", {16'b0, bus.result}, 32'h40);
    cycle(1, 11, 8, 1, 0, 1); check("sll_81", {16'b0, bus.result}, 32'h02);
    cycle(0, 0, 0, 0, 0, 1);  check("drain", {31'b0, bus.out_valid}, 0);

    // Backpressure: held result blocks the next ADD until out_ready rises
    cycle(1, 9, 3, 5, 0, 0);
    held = 15;
    cycle(1, 7, 3, 4, 0, 0);
    check("bp_in_ready", {31'b0, bus.in_ready}, 0);
    check("bp_stable", {16'b0, bus.result}, held);
    cycle(1, 7, 3, 4, 0, 1);  check("bp_add", {16'b0, bus.result}, 32'h7);

    // Overflow run
    cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 258; i++) begin
      cycle(1, 15, 15, 15, 0, 1);
      if (i == 256) begin
        check("acc257_res", {16'b0, bus.result}, 32'hFFFF);
        check("acc257_ovf", {31'b0, bus.acc_ovf}, 0);
      end
    end
`ifdef ALU_SAT_EN
    check("acc258_res", {16'b0, bus.result}, 32'hFFFF);
`else
    check("acc258_res", {16'b0, bus.result}, 32'hFE);
`endif
    check("acc258_ovf", {31'b0, bus.acc_ovf}, 1);

    // Clear + add in the same cycle
    cycle(1, 15, 1, 2, 1, 1);
    check("clradd_res", {16'b0, bus.result}, 32'h12);
    check("clradd_ovf", {31'b0, bus.acc_ovf}, 0);
    // Stalled ACC with clear, then the op lands on a cleared accumulator
    cycle(1, 15, 0, 3, 0, 0);
    cycle(1, 15, 0, 3, 1, 0);
    cycle(1, 15, 0, 3, 0, 1);
    check("stall_clr_add", {16'b0, bus.result}, 32'h3);

    // Reset mid-transaction with a result held
    cycle(1, 15, 15, 15, 0, 0);
    cycle(1, 7, 1, 1, 0, 0);
    rst_n = 0;
    #1;
    check("arst_out_valid", {31'b0, bus.out_valid}, 0);
    check("arst_result", {16'b0, bus.result}, 0);
    check("arst_acc_ovf", {31'b0, bus.acc_ovf}, 0);
    check("arst_in_ready", {31'b0, bus.in_ready}, 1);
    m_ov = 0; m_res = 0; m_acc = 0; m_ovf = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    cycle(1, 15, 0, 1, 0, 1); check("post_rst_acc", {16'b0, bus.result}, 32'h1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 3) != 0) ? 1 : 0, $urandom_range(0, 15),
            $urandom_range(0, 15), $urandom_range(0, 15),
            ($urandom_range(0, 31) == 0) ? 1 : 0,
            ($urandom_range(0, 3) != 0) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
